// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-port unified memory
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          win_d;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic          grant_d, grant_i;

  // state register; reset abandons any in-flight access without an ack
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state, grant decision and per-state strobes
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    mem_en    = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (d_req && !(i_req && streak == SW'(MAX_D_STREAK))) grant_d = 1'b1;
        else if (i_req)                                        grant_i = 1'b1;
        if (grant_d || grant_i) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        i_ack     = !win_d;
        d_ack     = win_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant latching, streak tracking, latency countdown and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      win_d     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      streak    <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant_d || grant_i) begin
        win_d    <= grant_d;
        mem_we   <= grant_d && d_we;
        mem_addr <= grant_d ? d_addr : i_addr;
        if (grant_d) mem_wdata <= d_wdata;
        // streak only grows while a fetch is actually being held off
        if (grant_i)    streak <= '0;
        else if (i_req) streak <= streak + 1'b1;
        else            streak <= '0;
      end
      if (state == ISSUE)                  cnt <= CW'(MEM_LATENCY - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0) begin
        if (!win_d)       i_rdata <= mem_rdata;
        else if (!mem_we) d_rdata <= mem_rdata;
      end
    end
  end

endmodule
